osc_decimator: RTL
==================

# osc_decimator

Decimating averager placed directly downstream of the oscilloscope input filter stage. It consumes the filtered 16-bit signed sample stream over AXI-Stream, sums each window of N accepted samples, and emits one shifted, saturated result per window to the acquisition buffer writer. When the averaging feature is compiled out, it subsamples instead, emitting the first sample of each window.

## Interface
Parameters:
- DW, 16, sample width (signed two's complement) on both streams
- CW, 17, decimation counter width; maximum factor is 2^CW-1

Ports:
- clk  in  1  sample clock
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  DW  filtered sample, signed
- s_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  constant 1; the block never back-pressures
- m_axis_tdata  out  DW  decimated sample, signed
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream accept
- cfg_dec  in  CW  decimation factor N; a value of 0 is treated as 1
- cfg_shift  in  5  arithmetic right shift applied to the window sum; values above CW are clamped to CW
- cfg_ovf_clr  in  1  one-cycle pulse that clears sts_ovf
- sts_ovf  out  1  sticky flag: a result was dropped because the output was stalled

## Operation
- An input sample is accepted on any cycle with s_axis_tvalid=1, since tready is always 1.
- Window counter `cnt` (CW bits) increments on each accepted sample.
- On the sample where cnt==N-1:
  - cnt wraps to 0.
  - The window closes and a result is produced.
- Averaging path:
  - Accumulator `acc` has width DW+CW and is signed.
  - The first sample of a window loads acc; each later sample adds to it.
  - Result = (acc including the closing sample) >>> cfg_shift, saturated to the range [-2^(DW-1), 2^(DW-1)-1].
- Output register:
  - When a result is produced and the slot is free (m_axis_tvalid=0, or m_axis_tready=1 in the same cycle), load m_axis_tdata and set m_axis_tvalid=1.
  - When the slot is occupied (m_axis_tvalid=1 and m_axis_tready=0), drop the new result, keep tdata stable, and set sts_ovf.
- m_axis_tvalid clears on a handshake (tvalid and tready both 1) when no new result is loaded in that same cycle.
- Configuration change detection:
  - cfg_dec and cfg_shift are registered every cycle.
  - If either differs from its registered copy, cnt and acc clear on the next edge and the partial window is discarded without producing output.
  - An input accepted in the cycle where the change is detected is discarded.
- sts_ovf:
  - Set by a dropped result, cleared by cfg_ovf_clr.
  - If a set and a clear occur in the same cycle, set wins.
- N=1: every accepted sample yields a result, which equals (sample <<< 0) >>> shift.

## Timing
- Latency: the result appears on m_axis_tdata/m_axis_tvalid one clk after the edge that accepts the window's last sample.
- Throughput: one result per N accepted samples; gaps in s_axis_tvalid stretch the window but do not reset it.
- Values on reset (rst=1 at a clock edge):
  - m_axis_tdata=0, m_axis_tvalid=0, sts_ovf=0.
  - cnt=0 and acc=0.
  - Configuration shadow registers load the current cfg values.
  - s_axis_tready stays 1 during reset.
- Reset mid-window or mid-stall discards the partial window and any pending output. There is no output on the first edge after reset release.
- AXI rule: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata must not change.
- Saturation and shift are combinational on the closing sample and are registered into m_axis_tdata. No extra pipeline stage is added.

## Configuration
- Macro `OSC_DEC_AVG_EN`.
- When defined: the accumulator and the shift/saturate logic are present, and the block averages as described above.
- When undefined:
  - There is no accumulator.
  - The result is the first accepted sample of each window, passed unmodified.
  - cfg_shift is ignored.
  - Windowing, latency, overflow handling, and reset behaviour are identical to the defined case.

## Test plan
- Averaging, normal: OSC_DEC_AVG_EN defined, N=4, shift=2, inputs 100, 200, 300, 400 with continuous valid and tready=1 → a single output of 250, one clk after the 400 is accepted.
- Saturation: N=8, shift=0, eight inputs of 0x7FFF → output 0x7FFF. Eight inputs of 0x8000 → output 0x8000.
- Stall and overflow: N=1, m_axis_tready=0, inputs 5 then 6 → tdata holds 5, sts_ovf=1. Raise tready → 5 is consumed, tvalid drops. Pulse cfg_ovf_clr → sts_ovf=0.
- Reconfiguration mid-window: N=4, feed 2 samples, change N to 2, then feed 10 and 20 → single output (10+20)>>>shift. No output from the first 2 samples.
- Valid gaps and reset: N=3 with tvalid toggling 1,0,1,0,1 → one output after the third accepted sample. Assert rst after 2 samples of a later window → all outputs 0, and the next window starts from a clean state.
- Subsample build: OSC_DEC_AVG_EN undefined, N=3, inputs 7, 8, 9, 10, 11, 12 → outputs 7 then 10.

Source files
------------

// File: rtl/osc_decimator.sv
// osc_decimator: decimating averager for the filtered oscilloscope sample stream.
// Accepts signed samples over AXI-Stream and emits one result per window of N
// accepted samples. The OSC_DEC_AVG_EN macro selects the averaging build:
//   defined   : result = window sum >>> cfg_shift, saturated to DW bits
//   undefined : result = first accepted sample of the window (subsampling)
// A result that arrives while the output slot is stalled is dropped and
// recorded in the sticky sts_ovf flag.
module osc_decimator #(
  parameter int DW = 16,
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  input  logic [CW-1:0] cfg_dec,
  input  logic [4:0]    cfg_shift,
  input  logic          cfg_ovf_clr,
  output logic          sts_ovf
);

  localparam int AW = DW + CW;

  logic [CW-1:0] dec_reg;
  logic [4:0]    shift_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] tdata_reg;
  logic          tvalid_reg;
  logic          ovf_reg;

  logic          cfg_change;
  logic [CW-1:0] cnt_last;
  logic          accept;
  logic          close;
  logic          slot_free;
  logic [DW-1:0] result;

  // Window bookkeeping: detect config edits, find the closing sample, and
  // decide whether the output slot can take a new result this cycle.
  always_comb begin
    cfg_change = (cfg_dec != dec_reg) || (cfg_shift != shift_reg);
    // A factor of 0 behaves like 1, so the window closes at cnt == 0.
    cnt_last   = (dec_reg == '0) ? '0 : dec_reg - CW'(1);
    accept     = s_axis_tvalid && !cfg_change;
    close      = accept && (cnt_reg == cnt_last);
    slot_free  = !tvalid_reg || m_axis_tready;
  end

`ifdef OSC_DEC_AVG_EN
  localparam logic [4:0] SHIFT_MAX = 5'(CW);
  localparam logic signed [AW-1:0] SAT_MAX = $signed({{(CW + 1){1'b0}}, {(DW - 1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_MIN = $signed({{(CW + 1){1'b1}}, {(DW - 1){1'b0}}});

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] shifted;
  logic [4:0]           shift_amt;

  // Running sum including the current sample, then shift and saturate it.
  always_comb begin
    sample_ext = $signed({{CW{s_axis_tdata[DW-1]}}, s_axis_tdata});
    sum        = (cnt_reg == '0) ? sample_ext : acc_reg + sample_ext;
    shift_amt  = (shift_reg > SHIFT_MAX) ? SHIFT_MAX : shift_reg;
    shifted    = sum >>> shift_amt;
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DW-1:0];
    end else begin
      result = shifted[DW-1:0];
    end
  end

  // Accumulator: first sample of a window loads, later samples add.
  always_ff @(posedge clk) begin
    if (rst || cfg_change) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= sum;
    end
  end
`else
  logic [DW-1:0] first_reg;

  // Result is the window's first sample; for N=1 that is the current one.
  always_comb begin
    result = (cnt_reg == '0) ? s_axis_tdata : first_reg;
  end

  // Capture the first accepted sample of every window.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_reg <= '0;
    end else if (accept && (cnt_reg == '0)) begin
      first_reg <= s_axis_tdata;
    end
  end
`endif

  // Shadow copies of the configuration, refreshed every cycle.
  always_ff @(posedge clk) begin
    dec_reg   <= cfg_dec;
    shift_reg <= cfg_shift;
  end

  // Window counter: wraps on the closing sample, cleared by a config edit.
  always_ff @(posedge clk) begin
    if (rst || cfg_change) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= close ? '0 : cnt_reg + CW'(1);
    end
  end

  // Output slot: load a result when free, otherwise hold; drop on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
    end else if (close && slot_free) begin
      tdata_reg  <= result;
      tvalid_reg <= 1'b1;
    end else if (tvalid_reg && m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (close && !slot_free) begin
      ovf_reg <= 1'b1;
    end else if (cfg_ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign sts_ovf       = ovf_reg;

endmodule
